aiq_dispatch_steer: RTL and testbench
=====================================

// Module: aiq_dispatch_steer
// PURPOSE
//  Dispatch-side controller for the two-bank arithmetic issue queue. Each cycle it steers up to
//  two renamed instructions (slot 0 older than slot 1) onto the two single-entry-per-cycle bank
//  write ports. It tracks free entries per bank with credit counters and raises int_stall on a
//  structural hazard. Across a branch recall it blocks dispatch until squashed entries are returned.
// PARAMETERS
//  BANK_DEPTH  8  entries per AIQ bank; credit counters reset to this value
//  CW          $clog2(BANK_DEPTH+1)  credit/squash-count width (derived, not overridden)
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous active-high reset
//  ext_stall        in   1        downstream freeze; no dispatch this cycle
//  in_valid         in   [1:0]    renamed instr valid per rename slot
//  bank_issue       in   [1:0]    bank b issued (freed) one entry this cycle
//  if_recall        in   1        branch recall pulse
//  squash_valid     in   1        squash_cnt valid (1 pulse, >=1 cycle after if_recall)
//  squash_cnt       in   [1:0][CW-1:0]  entries bank b dropped on recall
//  out_valid        out  [1:0]    write bank b this cycle
//  out_sel          out  [1:0]    rename slot routed to bank b (0/1)
//  int_stall        out  1        rename group not accepted (structural/recall)
//  credits          out  [1:0][CW-1:0]  current free-entry count per bank (registered)
//  credit_err       out  1        sticky: credit overflow/underflow detected
// BEHAVIOUR
//  Reset: credits=BANK_DEPTH both; rr_ptr=0; state=RUN; credit_err=0.
//    out_valid=0, int_stall=0 while reset is high.
//  States: RUN, RECOVER.
//    RUN->RECOVER on if_recall. RECOVER->RUN in the cycle squash_valid=1.
//    if_recall in RECOVER is ignored; stay in RECOVER.
//  Dispatch decision is combinational from registered credits/state (0-cycle latency).
//  Dispatch is enabled only when state==RUN && !if_recall && !ext_stall && !reset.
//  Two valid (in_valid=2'b11): needs credits[0]>0 && credits[1]>0.
//    Else no dispatch and int_stall=1; the group is all-or-nothing.
//    Slot 0 goes to the bank with more credits; on a tie, slot 0 goes to bank rr_ptr.
//    Slot 1 goes to the other bank.
//  One valid (slot k): goes to the bank with more credits (tie -> rr_ptr).
//    int_stall=1 if the chosen bank has credit 0, i.e. both banks are 0.
//  None valid: out_valid=0, int_stall=0.
//  int_stall=1 in RECOVER or when if_recall=1 if any in_valid bit is set.
//    int_stall is NOT asserted for ext_stall alone.
//  rr_ptr toggles on every cycle in which any tie was resolved by it.
//  Credit update, every cycle including ext_stall and RECOVER:
//    credits[b] <= credits[b] - out_valid[b] + bank_issue[b] + (squash_valid ? squash_cnt[b] : 0)
//    Compute with 1 extra bit. Issue and dispatch in the same cycle leave the count unchanged.
//  Result > BANK_DEPTH: saturate to BANK_DEPTH and set credit_err.
//    Result < 0 cannot happen via dispatch; bank_issue at credit==BANK_DEPTH sets credit_err.
//  squash_valid outside RECOVER: counts are still applied; credit_err is set.
//  Reset mid-RECOVER returns to RUN with full credits.
// TESTING
//  Reset, both valid, credits 8/8, rr=0: out_valid=11, out_sel[0]=0, out_sel[1]=1.
//    Next cycle credits=7/7, rr=1.
//  Hold in_valid=01 for 16 cycles, no issue: alternates banks, credits reach 0/0.
//    Cycle 17: int_stall=1, out_valid=00.
//  Credits 0/5, in_valid=11 -> int_stall=1, no writes.
//    Same cycle bank_issue=01 -> credits 1/5, group dispatches next cycle.
//  Credits 3/3, out_valid[0] and bank_issue[0] same cycle -> credits[0] stays 3.
//    ext_stall=1 with bank_issue=10 -> credits[1]=4, int_stall=0.
//  Credits 2/4, if_recall, squash_valid 2 cycles later with squash_cnt 3/4:
//    int_stall=1 for the 3 cycles, then credits 5/8, state RUN.
//  Credits 8/8 with bank_issue=01 -> credits[0] stays 8 and credit_err latches 1 until reset.

Source files
------------

// File: rtl/aiq_dispatch_steer_if.sv
// Dispatch-steer bus for the two-bank arithmetic issue queue.
//   master : rename/recall side. Drives ext_stall, in_valid, bank_issue, if_recall,
//            squash_valid and squash_cnt. Observes the steering results.
//   slave  : aiq_dispatch_steer. Drives out_valid, out_sel, int_stall, credits and credit_err.
// Per-bank vectors are indexed by bank (0/1). The one exception is in_valid, which is
// indexed by rename slot.
interface aiq_dispatch_steer_if #(
  parameter int BANK_DEPTH = 8
);
  localparam int CW = $clog2(BANK_DEPTH + 1);

  logic                 ext_stall;
  logic [1:0]           in_valid;
  logic [1:0]           bank_issue;
  logic                 if_recall;
  logic                 squash_valid;
  logic [1:0][CW-1:0]   squash_cnt;
  logic [1:0]           out_valid;
  logic [1:0]           out_sel;
  logic                 int_stall;
  logic [1:0][CW-1:0]   credits;
  logic                 credit_err;

  modport master (
    output ext_stall, in_valid, bank_issue, if_recall, squash_valid, squash_cnt,
    input  out_valid, out_sel, int_stall, credits, credit_err
  );

  modport slave (
    input  ext_stall, in_valid, bank_issue, if_recall, squash_valid, squash_cnt,
    output out_valid, out_sel, int_stall, credits, credit_err
  );
endinterface

// File: rtl/aiq_dispatch_steer.sv
// aiq_dispatch_steer: steers up to two renamed instructions per cycle onto the two
// AIQ bank write ports. Slot 0 is the older instruction. The block keeps a free-entry
// credit counter for each bank. Dispatch is held off during a branch recall until the
// squashed entries have been returned.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : aiq_dispatch_steer_if slave. Carries rename valids, bank issue/free
//                pulses, recall/squash, steering outputs, credits and a sticky credit
//                error flag.
// The steering decision is combinational and is computed from registered state. Credits
// and the error flag are registered.
module aiq_dispatch_steer #(
  parameter int BANK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  aiq_dispatch_steer_if.slave  bus
);
  localparam int CW = $clog2(BANK_DEPTH + 1);

  typedef logic [CW:0] wide_t;
  typedef enum logic [0:0] {ST_RUN, ST_RECOVER} state_t;

  state_t             state_q, state_d;
  logic [1:0][CW-1:0] credits_q, credits_d;
  logic               rr_q, rr_d;
  logic               err_q, err_d;

  logic [1:0]         out_valid;
  logic [1:0]         out_sel;
  logic               int_stall;
  logic               tie_used;

  logic               tie;
  logic               pick;
  logic               has0, has1;
  wide_t              sum;

  // Steering: the preferred bank is the one with more free entries. A tie goes to
  // rr_ptr. When both slots are valid, the group dispatches only if it can fully
  // dispatch, so it never splits.
  always_comb begin
    out_valid = '0;
    out_sel   = '0;
    int_stall = 1'b0;
    tie_used  = 1'b0;
    tie       = (credits_q[0] == credits_q[1]);
    pick      = tie ? rr_q : (credits_q[1] > credits_q[0]);
    has0      = (credits_q[0] != '0);
    has1      = (credits_q[1] != '0);
    if (!reset) begin
      if (state_q == ST_RECOVER || bus.if_recall) begin
        int_stall = |bus.in_valid;
      end else if (!bus.ext_stall) begin
        unique case (bus.in_valid)
          2'b11: begin
            if (has0 && has1) begin
              out_valid      = 2'b11;
              out_sel[pick]  = 1'b0;
              out_sel[~pick] = 1'b1;
              tie_used       = tie;
            end else begin
              int_stall = 1'b1;
            end
          end
          2'b01, 2'b10: begin
            if (pick ? has1 : has0) begin
              out_valid[pick] = 1'b1;
              out_sel[pick]   = bus.in_valid[1];
              tie_used        = tie;
            end else begin
              int_stall = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next state: credit accounting, the recall FSM and the round-robin pointer.
  // The sum is one bit wider than the counter, so an overflow shows up before the
  // value saturates. A write only happens when the bank has credit, so the
  // subtraction cannot go negative.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q ^ tie_used;
    err_d     = err_q;
    credits_d = credits_q;
    sum       = '0;

    unique case (state_q)
      ST_RUN:     if (bus.if_recall)    state_d = ST_RECOVER;
      ST_RECOVER: if (bus.squash_valid) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase

    if (bus.squash_valid && state_q != ST_RECOVER) err_d = 1'b1;

    for (int unsigned b = 0; b < 2; b++) begin
      sum = wide_t'(credits_q[b]) + wide_t'(bus.bank_issue[b])
          + (bus.squash_valid ? wide_t'(bus.squash_cnt[b]) : '0)
          - wide_t'(out_valid[b]);
      if (sum > wide_t'(BANK_DEPTH)) begin
        credits_d[b] = CW'(BANK_DEPTH);
        err_d        = 1'b1;
      end else begin
        credits_d[b] = sum[CW-1:0];
      end
      // An issue while the bank is already empty means the issue and dispatch
      // sides have lost agreement.
      if (bus.bank_issue[b] && credits_q[b] == CW'(BANK_DEPTH)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      credits_q <= {2{CW'(BANK_DEPTH)}};
      rr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_sel    = out_sel;
  assign bus.int_stall  = int_stall;
  assign bus.credits    = credits_q;
  assign bus.credit_err = err_q;
endmodule

// File: tb/tb_aiq_dispatch_steer.sv
module tb_aiq_dispatch_steer;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  aiq_dispatch_steer_if #(.BANK_DEPTH(8)) bus ();

  aiq_dispatch_steer #(.BANK_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ext_stall    = 1'b0;
    bus.in_valid     = 2'b00;
    bus.bank_issue   = 2'b00;
    bus.if_recall    = 1'b0;
    bus.squash_valid = 1'b0;
    bus.squash_cnt   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 2'b11;
      tick();
    end
    bus.in_valid = 2'b00;
  endtask

  logic [1:0] alt_pat [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    alt_pat[0] = 2'b01; alt_pat[1] = 2'b10; alt_pat[2] = 2'b10; alt_pat[3] = 2'b01;
    reset = 1'b1;
    idle_inputs();
    tick();

    // While reset is held, no write or stall may appear, even with valid inputs.
    bus.in_valid = 2'b11;
    #2;
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_int_stall", 16'(bus.int_stall), 16'h0);
    tick();
    reset = 1'b0;
    bus.in_valid = 2'b00;
    #2;
    chk("rst_credits", 16'(bus.credits), 16'h88);
    chk("rst_err", 16'(bus.credit_err), 16'h0);

    // First pair at 8/8 with rr=0: slot0 goes to bank0 and slot1 to bank1.
    bus.in_valid = 2'b11;
    #2;
    chk("pair_out_valid", 16'(bus.out_valid), 16'h3);
    chk("pair_out_sel", 16'(bus.out_sel), 16'h2);
    chk("pair_stall", 16'(bus.int_stall), 16'h0);
    tick();
    bus.in_valid = 2'b00;
    chk("pair_credits", 16'(bus.credits), 16'h77);
    // rr is now 1, so a single instruction on the 7/7 tie goes to bank1.
    bus.in_valid = 2'b01;
    #2;
    chk("rr_toggled", 16'(bus.out_valid), 16'h2);

    // Single slot held for 16 cycles alternates banks in the pattern 01,10,10,01.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 2'b01;
      #2;
      chk($sformatf("single_%0d", i), 16'({bus.int_stall, bus.out_valid}), 16'(alt_pat[i % 4]));
      tick();
    end
    #2;
    chk("drain_credits", 16'(bus.credits), 16'h00);
    chk("drain_stall", 16'(bus.int_stall), 16'h1);
    chk("drain_out_valid", 16'(bus.out_valid), 16'h0);

    // Build 0/5, then a pair stalls. A bank0 issue in the same cycle frees one entry.
    bus.in_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      bus.bank_issue = 2'b10;
      tick();
    end
    bus.bank_issue = 2'b00;
    chk("c05", 16'(bus.credits), 16'h50);
    bus.in_valid   = 2'b11;
    bus.bank_issue = 2'b01;
    #2;
    chk("c05_stall", 16'(bus.int_stall), 16'h1);
    chk("c05_nowrite", 16'(bus.out_valid), 16'h0);
    tick();
    bus.bank_issue = 2'b00;
    chk("c15", 16'(bus.credits), 16'h51);
    #1;
    chk("c15_out_valid", 16'(bus.out_valid), 16'h3);
    chk("c15_out_sel", 16'(bus.out_sel), 16'h1);
    chk("c15_stall", 16'(bus.int_stall), 16'h0);
    tick();
    bus.in_valid = 2'b00;
    chk("c04", 16'(bus.credits), 16'h40);

    // At 3/3, a dispatch and an issue to the same bank cancel. Then ext_stall lets an issue land.
    do_reset();
    run_pairs(5);
    chk("c33", 16'(bus.credits), 16'h33);
    bus.in_valid   = 2'b11;
    bus.bank_issue = 2'b11;
    #2;
    chk("c33_out_valid", 16'(bus.out_valid), 16'h3);
    tick();
    chk("c33_hold", 16'(bus.credits), 16'h33);
    bus.ext_stall  = 1'b1;
    bus.bank_issue = 2'b10;
    #2;
    chk("ext_stall_nostall", 16'(bus.int_stall), 16'h0);
    chk("ext_stall_nowrite", 16'(bus.out_valid), 16'h0);
    tick();
    idle_inputs();
    chk("ext_stall_credits", 16'(bus.credits), 16'h43);

    // Recall at 2/4 with squash 3/4 two cycles later: 3 stall cycles, then 5/8.
    do_reset();
    run_pairs(6);
    for (int i = 0; i < 2; i++) begin
      bus.bank_issue = 2'b10;
      tick();
    end
    bus.bank_issue = 2'b00;
    chk("c24", 16'(bus.credits), 16'h42);
    bus.in_valid  = 2'b11;
    bus.if_recall = 1'b1;
    #2;
    chk("recall_stall0", 16'({bus.int_stall, bus.out_valid}), 16'h4);
    tick();
    bus.if_recall = 1'b0;
    #2;
    chk("recall_stall1", 16'({bus.int_stall, bus.out_valid}), 16'h4);
    tick();
    bus.squash_valid  = 1'b1;
    bus.squash_cnt[0] = 4'd3;
    bus.squash_cnt[1] = 4'd4;
    #2;
    chk("recall_stall2", 16'({bus.int_stall, bus.out_valid}), 16'h4);
    tick();
    bus.squash_valid = 1'b0;
    bus.squash_cnt   = '0;
    chk("recall_credits", 16'(bus.credits), 16'h85);
    #1;
    chk("recall_run", 16'({bus.int_stall, bus.out_valid, bus.out_sel}), 16'hD);
    chk("recall_noerr", 16'(bus.credit_err), 16'h0);
    idle_inputs();

    // A reset during RECOVER returns the block to RUN with full credits.
    do_reset();
    bus.if_recall = 1'b1;
    tick();
    bus.if_recall = 1'b0;
    bus.in_valid  = 2'b11;
    #2;
    chk("in_recover_stall", 16'(bus.int_stall), 16'h1);
    do_reset();
    bus.in_valid = 2'b11;
    #2;
    chk("post_rst_dispatch", 16'({bus.int_stall, bus.out_valid}), 16'h3);
    bus.in_valid = 2'b00;

    // An issue at full credit saturates the counter and sets the sticky error.
    do_reset();
    bus.bank_issue = 2'b01;
    tick();
    bus.bank_issue = 2'b00;
    chk("ovf_credits", 16'(bus.credits), 16'h88);
    chk("ovf_err", 16'(bus.credit_err), 16'h1);
    tick(); tick(); tick();
    chk("err_sticky", 16'(bus.credit_err), 16'h1);
    do_reset();
    chk("err_cleared", 16'(bus.credit_err), 16'h0);

    // squash_valid while in RUN is applied, and the error flag is set.
    bus.squash_valid = 1'b1;
    tick();
    bus.squash_valid = 1'b0;
    chk("squash_run_err", 16'(bus.credit_err), 16'h1);
    chk("squash_run_credits", 16'(bus.credits), 16'h88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
